// File: rtl/lbm_stream_buffer.sv
// rtl/lbm_stream_buffer.sv - D2Q9 lattice-Boltzmann streaming buffer with bounce-back walls
module lbm_stream_buffer #(
    parameter int NX = 4,
    parameter int NY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] f0i,
    input  logic [15:0] f1i,
    input  logic [15:0] f2i,
    input  logic [15:0] f3i,
    input  logic [15:0] f4i,
    input  logic [15:0] f5i,
    input  logic [15:0] f6i,
    input  logic [15:0] f7i,
    input  logic [15:0] f8i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] f0o,
    output logic [15:0] f1o,
    output logic [15:0] f2o,
    output logic [15:0] f3o,
    output logic [15:0] f4o,
    output logic [15:0] f5o,
    output logic [15:0] f6o,
    output logic [15:0] f7o,
    output logic [15:0] f8o,
    output logic [3:0]  out_x,
    output logic [3:0]  out_y,
    output logic        out_last
);

    localparam int NSLOT = NX * NY * 9;
    localparam int AW    = $clog2(NSLOT);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t      state;
    logic [3:0]  lx, ly;
    logic [3:0]  dx, dy;
    logic [15:0] mem  [NSLOT];
    logic [15:0] fin  [9];
    logic [15:0] fout [9];

    assign fin[0] = f0i;
    assign fin[1] = f1i;
    assign fin[2] = f2i;
    assign fin[3] = f3i;
    assign fin[4] = f4i;
    assign fin[5] = f5i;
    assign fin[6] = f6i;
    assign fin[7] = f7i;
    assign fin[8] = f8i;

    // x component of direction k
    function automatic int cx(input int k);
        case (k)
            1, 6, 7: return 1;
            2, 5, 8: return -1;
            default: return 0;
        endcase
    endfunction

    // y component of direction k (north is +y)
    function automatic int cy(input int k);
        case (k)
            4, 6, 8: return 1;
            3, 5, 7: return -1;
            default: return 0;
        endcase
    endfunction

    // Direction pointing the opposite way, used for bounce-back at walls
    function automatic int opp(input int k);
        case (k)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            5: return 6;
            6: return 5;
            7: return 8;
            8: return 7;
            default: return 0;
        endcase
    endfunction

    // Slot that f_k of cell (x,y) lands in: neighbour's slot k, or own opposite slot at a wall
    function automatic logic [AW-1:0] dest_addr(input logic [3:0] x, input logic [3:0] y, input int k);
        int tx;
        int ty;
        tx = int'(x) + cx(k);
        ty = int'(y) + cy(k);
        if (tx >= 0 && tx < NX && ty >= 0 && ty < NY)
            return AW'((ty * NX + tx) * 9 + k);
        return AW'((int'(y) * NX + int'(x)) * 9 + opp(k));
    endfunction

    // Read all nine slots of the cell at the drain counter
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            fout[k] = mem[AW'((int'(dy) * NX + int'(dx)) * 9 + k)];
        end
    end

    assign f0o      = fout[0];
    assign f1o      = fout[1];
    assign f2o      = fout[2];
    assign f3o      = fout[3];
    assign f4o      = fout[4];
    assign f5o      = fout[5];
    assign f6o      = fout[6];
    assign f7o      = fout[7];
    assign f8o      = fout[8];
    assign out_x    = dx;
    assign out_y    = dy;
    assign out_last = out_valid && (dx == 4'(NX - 1)) && (dy == 4'(NY - 1));

    // Load/drain FSM: scatters accepted cells into the array, then streams the frame out
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lx        <= '0;
            ly        <= '0;
            dx        <= '0;
            dy        <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < 9; k++) begin
                            mem[dest_addr(lx, ly, k)] <= fin[k];
                        end
                        if (lx == 4'(NX - 1)) begin
                            lx <= '0;
                            if (ly == 4'(NY - 1)) begin
                                ly        <= '0;
                                state     <= DRAIN;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                ly <= ly + 4'd1;
                            end
                        end else begin
                            lx <= lx + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (dx == 4'(NX - 1)) begin
                            dx <= '0;
                            if (dy == 4'(NY - 1)) begin
                                dy        <= '0;
                                state     <= LOAD;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                            end else begin
                                dy <= dy + 4'd1;
                            end
                        end else begin
                            dx <= dx + 4'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_stream_buffer.sv
// tb/tb_lbm_stream_buffer.sv - scoreboard bench for lbm_stream_buffer (NX=NY=4)
module tb_lbm_stream_buffer;

    typedef struct packed {
        logic [3:0]   x;
        logic [3:0]   y;
        logic         last;
        logic [143:0] fv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] fi [9];
    logic        in_ready, out_valid, out_last;
    logic [15:0] f0o, f1o, f2o, f3o, f4o, f5o, f6o, f7o, f8o;
    logic [3:0]  out_x, out_y;

    exp_t        q[$];
    logic [15:0] din [16][9];
    logic [15:0] exf [16][9];
    int          vectors = 0;
    int          miscompares = 0;
    int          hs_count = 0;
    int          acc_count = 0;
    logic        held = 1'b0;
    logic [152:0] snap;
    exp_t        e;

    wire [143:0] fv_act = {f8o, f7o, f6o, f5o, f4o, f3o, f2o, f1o, f0o};

    lbm_stream_buffer #(.NX(4), .NY(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .f0i(fi[0]), .f1i(fi[1]), .f2i(fi[2]), .f3i(fi[3]), .f4i(fi[4]),
        .f5i(fi[5]), .f6i(fi[6]), .f7i(fi[7]), .f8i(fi[8]),
        .out_valid(out_valid), .out_ready(out_ready),
        .f0o(f0o), .f1o(f1o), .f2o(f2o), .f3o(f3o), .f4o(f4o),
        .f5o(f5o), .f6o(f6o), .f7o(f7o), .f8o(f8o),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every drain handshake, checks hold under stall
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_count++;
            if (out_valid) begin
                chk("in_ready_low_in_drain", 144'(in_ready), 144'(0));
                if (held) chk("stall_hold", 144'({out_x, out_y, out_last, fv_act} != snap), 144'(0));
                if (out_ready) begin
                    hs_count++;
                    held = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_output", 144'(1), 144'(0));
                    end else begin
                        e = q.pop_front();
                        chk("out_x", 144'(out_x), 144'(e.x));
                        chk("out_y", 144'(out_y), 144'(e.y));
                        chk("out_last", 144'(out_last), 144'(e.last));
                        chk("slots", fv_act, e.fv);
                    end
                end else begin
                    held = 1'b1;
                    snap = {out_x, out_y, out_last, fv_act};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic clear_frame();
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 9; k++) begin
                din[c][k] = 16'h0000;
                exf[c][k] = 16'h0000;
            end
        end
    endtask

    task automatic push_frame();
        exp_t t;
        for (int c = 0; c < 16; c++) begin
            t.x    = 4'(c % 4);
            t.y    = 4'(c / 4);
            t.last = (c == 15);
            for (int k = 0; k < 9; k++) t.fv[k*16 +: 16] = exf[c][k];
            q.push_back(t);
        end
    endtask

    task automatic load_cells(input int n);
        int g;
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 9; k++) fi[k] = din[c][k];
            in_valid = 1'b1;
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 50) begin
                g++;
                @(negedge clk);
            end
            if (g >= 50) chk("load_timeout", 144'(1), 144'(0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) fi[k] = 16'h0000;
    endtask

    task automatic drain(input bit bp, input bit garbage);
        int stalls;
        int cyc;
        int acc0;
        stalls = 0;
        cyc = 0;
        hs_count = 0;
        acc0 = acc_count;
        out_ready = 1'b1;
        if (garbage) begin
            in_valid = 1'b1;
            for (int k = 0; k < 9; k++) fi[k] = 16'hdea0 + 16'(k);
        end
        while (hs_count < 16 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bp && hs_count == 5 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            if (hs_count >= 16) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) fi[k] = 16'h0000;
        out_ready = 1'b0;
        if (cyc >= 300) chk("drain_timeout", 144'(1), 144'(0));
        chk("drain_handshakes", 144'(hs_count), 144'(16));
        chk("scoreboard_empty", 144'(q.size()), 144'(0));
        chk("inputs_accepted_in_drain", 144'(acc_count - acc0), 144'(0));
        @(negedge clk);
        chk("back_to_load_in_ready", 144'(in_ready), 144'(1));
        chk("back_to_load_out_valid", 144'(out_valid), 144'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 144'(in_ready), 144'(1));
        chk({tag, "_out_valid"}, 144'(out_valid), 144'(0));
        chk({tag, "_out_last"}, 144'(out_last), 144'(0));
        chk({tag, "_xy"}, 144'({out_x, out_y}), 144'(0));
        chk({tag, "_slots"}, fv_act, 144'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 9; k++) fi[k] = 16'h0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("reset");

        // (1,1) f1 streams east to (2,1); (2,2) f0 stays put
        clear_frame();
        din[5][1]  = 16'h1000;
        din[10][0] = 16'h8001;
        exf[6][1]  = 16'h1000;
        exf[10][0] = 16'h8001;
        push_frame();
        load_cells(16);
        drain(1'b0, 1'b0);

        // SW corner f5 and NE corner f6 bounce back into own opposite slots
        clear_frame();
        din[0][5]  = 16'h0400;
        din[15][6] = 16'h0123;
        exf[0][6]  = 16'h0400;
        exf[15][5] = 16'h0123;
        push_frame();
        load_cells(16);
        drain(1'b0, 1'b0);

        // NE corner: f2 streams west to (2,3), f7 hits the wall into slot 8
        clear_frame();
        din[15][2] = 16'h0055;
        din[15][7] = 16'h0011;
        exf[14][2] = 16'h0055;
        exf[15][8] = 16'h0011;
        push_frame();
        load_cells(16);
        drain(1'b0, 1'b0);

        // Interior cell (1,1): every direction streams to its own neighbour
        clear_frame();
        for (int k = 0; k < 9; k++) din[5][k] = 16'h8000 + 16'(k);
        exf[5][0]  = 16'h8000;
        exf[6][1]  = 16'h8001;
        exf[4][2]  = 16'h8002;
        exf[1][3]  = 16'h8003;
        exf[9][4]  = 16'h8004;
        exf[0][5]  = 16'h8005;
        exf[10][6] = 16'h8006;
        exf[2][7]  = 16'h8007;
        exf[8][8]  = 16'h8008;
        push_frame();
        load_cells(16);
        drain(1'b0, 1'b0);

        // Backpressure at cell 5 with junk offered on the input side
        clear_frame();
        din[5][1]  = 16'h1000;
        din[10][0] = 16'h8001;
        exf[6][1]  = 16'h1000;
        exf[10][0] = 16'h8001;
        push_frame();
        load_cells(16);
        drain(1'b1, 1'b1);

        // Partial frame abandoned by reset, then a fresh frame
        clear_frame();
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 9; k++) din[c][k] = 16'h7770 + 16'(k);
        end
        load_cells(7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("midload_reset");
        clear_frame();
        din[0][0]  = 16'h4242;
        din[15][4] = 16'h0bad;
        exf[0][0]  = 16'h4242;
        exf[15][3] = 16'h0bad;
        push_frame();
        load_cells(16);
        drain(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lbm_stream_buffer.md
LBM_STREAM_BUFFER -- requirements
Module: lbm_stream_buffer

Interface
REQ-001 SHALL have parameter NX, default 4, meaning grid width in cells (legal 2..16).
REQ-002 SHALL have parameter NY, default 4, meaning grid height in cells (legal 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a post-collision cell is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a cell this cycle.
REQ-007 SHALL have ports f0i..f8i, input, 16 bits signed 2.14 each: post-collision distributions of the presented cell.
REQ-008 SHALL have port out_valid, output, 1 bit: a streamed cell is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the presented cell.
REQ-010 SHALL have ports f0o..f8o, output, 16 bits signed each: pre-collision distributions of the presented cell.
REQ-011 SHALL have ports out_x and out_y, output, 4 bits each: coordinates of the presented cell.
REQ-012 SHALL have port out_last, output, 1 bit: the presented cell is (NX-1, NY-1).

Function
REQ-013 SHALL treat direction vectors as: 0 (0,0), 1 (+1,0), 2 (-1,0), 3 (0,-1), 4 (0,+1), 5 (-1,-1), 6 (+1,+1), 7 (+1,-1), 8 (-1,+1); y increases northward.
REQ-014 SHALL treat opposite pairs as 1/2, 3/4, 5/6, 7/8.
REQ-015 SHALL hold an NX*NY*9 array of 16-bit slots.
REQ-016 SHALL implement a two-state FSM: LOAD (reset state) and DRAIN.
REQ-017 In LOAD: in_ready=1, out_valid=0; a transfer occurs when in_valid and in_ready are both high.
REQ-018 SHALL assign accepted cells raster coordinates (x fastest, starting at (0,0)) from an internal load counter.
REQ-019 On transfer of cell (x,y): fk with k=1..8 SHALL be written to slot k of cell (x+cx, y+cy) when that cell is inside the grid.
REQ-020 When the destination lies outside the grid, fk SHALL be written to slot opposite(k) of cell (x,y) (bounce-back).
REQ-021 On transfer, f0 SHALL be written to slot 0 of cell (x,y).
REQ-022 SHALL pass values bit-exact: no arithmetic, saturation or sign change.
REQ-023 All nine writes of one transfer SHALL complete in the same cycle; one transfer per cycle maximum, no bubbles required.
REQ-024 After the transfer of cell (NX-1, NY-1), the FSM SHALL enter DRAIN on the next cycle and clear the load counter.
REQ-025 In DRAIN: in_ready=0; in_valid and f*i SHALL be ignored.
REQ-026 In DRAIN, out_valid=1; f0o..f8o, out_x and out_y SHALL reflect slots 0..8 of the cell at the drain counter, raster order.
REQ-027 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-028 The drain counter SHALL advance on out_valid and out_ready both high; out_last=1 only while presenting (NX-1, NY-1).
REQ-029 After the last drain handshake, the FSM SHALL return to LOAD on the next cycle with both counters at 0.
REQ-030 Back-to-back throughput SHALL be one cell per cycle in each phase.

Reset
REQ-031 While reset is high at a clock edge: state := LOAD, both counters := 0, all slots := 0.
REQ-032 Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_x=0, out_y=0, f0o..f8o=0.
REQ-033 Reset asserted mid-LOAD or mid-DRAIN SHALL abandon the frame; no partial data survives.
REQ-034 Reset SHALL take priority over a simultaneous handshake.

Verification
REQ-035 Reset check: assert reset 2 cycles -> in_ready=1, out_valid=0, out_last=0, all fko=0.
REQ-036 Streaming check (NX=NY=4): load 16 cells, zero except (1,1) f1i=16'h1000 and (2,2) f0i=16'h8001 -> drain gives (2,1) f1o=16'h1000, (2,2) f0o=16'h8001, all other slots 0.
REQ-037 Bounce-back check: (0,0) f5i=16'h0400 and (3,3) f6i=16'h0123 -> (0,0) f6o=16'h0400 and (3,3) f5o=16'h0123.
REQ-038 Corner check: (3,3) f2i=16'h0055, f7i=16'h0011 -> (2,3) f2o=16'h0055, (3,3) f8o=16'h0011.
REQ-039 Backpressure check: drop out_ready for 3 cycles at cell 5 and drive in_valid=1 during DRAIN -> outputs stable, exactly 16 drain handshakes, out_last on the 16th only, no input accepted.
REQ-040 Mid-load reset check: accept 7 cells, pulse reset, then load a full new frame -> drain contains only new-frame data, starting at (0,0).
